fb_write_queue: RTL and testbench

//  Buffers pixel writes from the colour-fill stage and drains them to the external

---
 rtl/fb_write_queue.sv | 165 ++++++++++++++++
 tb/tb_fb_write_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_queue.sv
// Pixel write queue between colour fill and the framebuffer SRAM.
// Merges same-address tail writes and drives a setup/strobe/hold cycle.
module fb_write_queue #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 24,
  parameter int DEPTH    = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              px_valid,
  input  logic [ADDR_W-1:0] px_addr,
  input  logic [DATA_W-1:0] px_data,
  output logic              px_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic          pend;
  logic          have;
  logic          push;
  logic          pop;
  logic          merge;
  logic          add;

  assign have     = (count != '0);
  assign px_ready = (count < CW'(DEPTH));
  assign push     = px_valid & px_ready;
  assign tail_ptr = wr_ptr - AW'(1);
  // Tail merge is unsafe when the lone entry leaves this cycle.
  assign merge    = push & have
                  & (addr_mem[tail_ptr] == px_addr)
                  & ~(pop & (count == CW'(1)));
  assign add      = push & ~merge;

  assign busy       = (state != IDLE) | have;
  assign flush_done = pend & ~have & (state == IDLE);

  // State register for the SRAM write cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and pop decision; pops happen only from IDLE and HOLD.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (have) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = STROBE;
      STROBE: begin
        if (wait_cnt == WW'(WAIT_CYC - 1))
          state_nxt = HOLD;
      end
      HOLD: begin
        if (have) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe-width counter, restarts outside STROBE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)               wait_cnt <= '0;
    else if (state != STROBE) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + WW'(1);
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (add) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({add, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; a merge only rewrites the tail pixel value.
  always_ff @(posedge clk) begin
    if (merge) begin
      data_mem[tail_ptr] <= px_data;
    end else if (push) begin
      addr_mem[wr_ptr] <= px_addr;
      data_mem[wr_ptr] <= px_data;
    end
  end

  // Registered SRAM bus; strobes decoded from the next state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      if (pop) begin
        sram_addr  <= addr_mem[rd_ptr];
        sram_wdata <= data_mem[rd_ptr];
      end
      sram_ce_n <= (state_nxt == IDLE);
      sram_we_n <= (state_nxt != STROBE);
    end
  end

  // Sticky record of pixels dropped while full.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                      overflow <= 1'b0;
    else if (px_valid && !px_ready)  overflow <= 1'b1;
  end

  // End-of-frame request held until the queue has drained.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)          pend <= 1'b0;
    else if (flush_done) pend <= 1'b0;
    else if (flush)      pend <= 1'b1;
  end

endmodule

// File: tb/tb_fb_write_queue.sv
// Directed bench for fb_write_queue.
// SRAM writes are captured on the falling edge of the write strobe.
module tb_fb_write_queue;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        px_valid;
  logic [18:0] px_addr;
  logic [23:0] px_data;
  logic        px_ready;
  logic        flush;
  logic        flush_done;
  logic [18:0] sram_addr;
  logic [23:0] sram_wdata;
  logic        sram_ce_n;
  logic        sram_we_n;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [42:0] wr_q [$];
  int ce_run = 0;
  int last_ce = 0;
  int ce_runs = 0;
  int we_run = 0;
  int last_we = 0;
  logic we_prev = 1'b1;

  fb_write_queue dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .px_valid   (px_valid),
    .px_addr    (px_addr),
    .px_data    (px_data),
    .px_ready   (px_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ce_n  (sram_ce_n),
    .sram_we_n  (sram_we_n),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Bus monitor on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!sram_ce_n) begin
        ce_run++;
      end else if (ce_run != 0) begin
        last_ce = ce_run;
        ce_runs++;
        ce_run = 0;
      end
      if (!sram_we_n) begin
        we_run++;
      end else if (we_run != 0) begin
        last_we = we_run;
        we_run = 0;
      end
      if (!sram_we_n && we_prev)
        wr_q.push_back({sram_addr, sram_wdata});
      we_prev = sram_we_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  initial begin
    int base;
    int runs0;
    int n;
    px_valid = 1'b0;
    px_addr  = '0;
    px_data  = '0;
    flush    = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;

    check("rst_ce", 64'(sram_ce_n), 64'd1);
    check("rst_we", 64'(sram_we_n), 64'd1);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_data", 64'(sram_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_fd", 64'(flush_done), 64'd0);
    check("rst_rdy", 64'(px_ready), 64'd1);

    // single write timing
    base = wr_q.size();
    px_valid = 1'b1;
    px_addr  = 19'h00123;
    px_data  = 24'hFF0000;
    tick();
    px_valid = 1'b0;
    check("t1_ce_e0", 64'(sram_ce_n), 64'd1);
    check("t1_busy_e0", 64'(busy), 64'd1);
    tick();
    check("t1_ce_e1", 64'(sram_ce_n), 64'd0);
    check("t1_we_e1", 64'(sram_we_n), 64'd1);
    check("t1_addr", 64'(sram_addr), 64'h123);
    check("t1_data", 64'(sram_wdata), 64'hFF0000);
    tick();
    check("t1_we_e2", 64'(sram_we_n), 64'd0);
    tick();
    check("t1_we_e3", 64'(sram_we_n), 64'd0);
    tick();
    check("t1_we_e4", 64'(sram_we_n), 64'd1);
    check("t1_ce_e4", 64'(sram_ce_n), 64'd0);
    tick();
    check("t1_ce_e5", 64'(sram_ce_n), 64'd1);
    check("t1_busy_e5", 64'(busy), 64'd0);
    tick();
    check("t1_ce_len", 64'(last_ce), 64'd4);
    check("t1_we_len", 64'(last_we), 64'd2);
    check("t1_nwr", 64'(wr_q.size() - base), 64'd1);
    check("t1_wr", 64'(wr_q[base]), {21'd0, 19'h00123, 24'hFF0000});

    // ten back-to-back writes
    base  = wr_q.size();
    runs0 = ce_runs;
    for (int i = 0; i < 10; i++) begin
      px_valid = 1'b1;
      px_addr  = 19'(i);
      px_data  = 24'(i * 32'h010101);
      n = 0;
      while (!px_ready && n < 50) begin
        tick();
        n++;
      end
      tick();
    end
    px_valid = 1'b0;
    wait_idle(200);
    tick();
    check("t2_ovf", 64'(overflow), 64'd0);
    check("t2_nwr", 64'(wr_q.size() - base), 64'd10);
    for (int i = 0; i < 10; i++)
      check("t2_wr", 64'(wr_q[base + i]),
            {21'd0, 19'(i), 24'(i * 32'h010101)});
    check("t2_runs", 64'(ce_runs - runs0), 64'd1);
    check("t2_ce_len", 64'(last_ce), 64'd40);

    // same-address merge behind a busy SRAM
    base = wr_q.size();
    px_valid = 1'b1;
    px_addr  = 19'd7;
    px_data  = 24'h123456;
    tick();
    px_addr  = 19'd5;
    px_data  = 24'h00AA00;
    tick();
    px_data  = 24'h0000BB;
    tick();
    px_valid = 1'b0;
    wait_idle(100);
    tick();
    check("t3_nwr", 64'(wr_q.size() - base), 64'd2);
    check("t3_wr0", 64'(wr_q[base]), {21'd0, 19'd7, 24'h123456});
    check("t3_wr1", 64'(wr_q[base + 1]), {21'd0, 19'd5, 24'h0000BB});

    // fill and overflow
    base = wr_q.size();
    for (int i = 0; i < 14; i++) begin
      px_valid = 1'b1;
      px_addr  = 19'(32'h100 + i);
      px_data  = 24'(32'hC00000 + i);
      tick();
      if (i == 9)  check("t4_rdy_e9", 64'(px_ready), 64'd1);
      if (i == 10) check("t4_rdy_e10", 64'(px_ready), 64'd0);
      if (i == 10) check("t4_ovf_e10", 64'(overflow), 64'd0);
      if (i == 11) check("t4_ovf_e11", 64'(overflow), 64'd1);
    end
    px_valid = 1'b0;
    wait_idle(300);
    tick();
    check("t4_ovf_end", 64'(overflow), 64'd1);
    check("t4_nwr", 64'(wr_q.size() - base), 64'd11);
    for (int i = 0; i < 11; i++)
      check("t4_wr", 64'(wr_q[base + i]),
            {21'd0, 19'(32'h100 + i), 24'(32'hC00000 + i)});

    // flush after three pixels
    base = wr_q.size();
    for (int i = 0; i < 3; i++) begin
      px_valid = 1'b1;
      px_addr  = 19'(32'h200 + i);
      px_data  = 24'(32'h00FF00 + i);
      tick();
    end
    px_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_fd_e3", 64'(flush_done), 64'd0);
    for (int e = 4; e <= 16; e++) begin
      flush = (e == 6);
      tick();
      check("t5_fd", 64'(flush_done), 64'(e == 13));
    end
    flush = 1'b0;
    check("t5_nwr", 64'(wr_q.size() - base), 64'd3);
    check("t5_wr2", 64'(wr_q[base + 2]), {21'd0, 19'h202, 24'h00FF02});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_idle_fd", 64'(flush_done), 64'd1);
    tick();
    check("t5_idle_fd_off", 64'(flush_done), 64'd0);

    // reset in the middle of a strobe
    px_valid = 1'b1;
    px_addr  = 19'h003AB;
    px_data  = 24'h777777;
    tick();
    px_valid = 1'b0;
    tick();
    tick();
    check("t6_we_pre", 64'(sram_we_n), 64'd0);
    #2;
    n_rst = 1'b0;
    #1;
    check("t6_ce_rst", 64'(sram_ce_n), 64'd1);
    check("t6_we_rst", 64'(sram_we_n), 64'd1);
    check("t6_busy_rst", 64'(busy), 64'd0);
    check("t6_rdy_rst", 64'(px_ready), 64'd1);
    check("t6_ovf_rst", 64'(overflow), 64'd0);
    tick();
    n_rst = 1'b1;
    base  = wr_q.size();
    runs0 = ce_runs;
    repeat (10) tick();
    check("t6_ce_after", 64'(sram_ce_n), 64'd1);
    check("t6_busy_after", 64'(busy), 64'd0);
    check("t6_nwr", 64'(wr_q.size() - base), 64'd0);
    check("t6_runs", 64'(ce_runs - runs0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
